// File: rtl/robs_pkg.sv
// Shared types for the Robertson sequential multiplier: FSM state encoding
// and operand-mode constants.
package robs_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } robs_state_t;

   localparam logic ROBS_UNSIGNED = 1'b0;
   localparam logic ROBS_SIGNED   = 1'b1;

endpackage

// File: rtl/robs_addsub.sv
// (WIDTH+1)-bit combinational adder/subtractor for the Robertson datapath.
// The extra bit carries the sign (signed mode) or the carry (unsigned mode).
module robs_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] s
);

   always_comb begin
      s = sub ? (a - b) : (a + b);
   end

endmodule

// File: rtl/robs_mult_seq.sv
// Sequential Robertson shift-and-add multiplier with start/done handshake.
// Define ROBS_OVF_EN to add the registered ovf output and its logic.
module robs_mult_seq
   import robs_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 tc,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     multiplicand,
   output logic                 busy,
   output logic                 done,
`ifdef ROBS_OVF_EN
   output logic                 ovf,
`endif
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   robs_state_t          state_q, state_d;
   logic [WIDTH-1:0]     x_q, x_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic                 tc_q, tc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH:0]       ext_a, ext_y, sum, s;
   logic                 sub;
   logic [2*WIDTH-1:0]   prod_nxt;

   // The multiplier's sign bit carries negative weight, so the last step subtracts.
   assign ext_a    = (tc_q == ROBS_SIGNED) ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
   assign ext_y    = (tc_q == ROBS_SIGNED) ? {y_q[WIDTH-1], y_q} : {1'b0, y_q};
   assign sub      = x_q[0] & (tc_q == ROBS_SIGNED) & (cnt_q == '0);
   assign s        = x_q[0] ? sum : ext_a;
   assign prod_nxt = {s, x_q[WIDTH-1:1]};

   robs_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a   (ext_a),
      .b   (ext_y),
      .sub (sub),
      .s   (sum)
   );

`ifdef ROBS_OVF_EN
   logic ovf_q, ovf_d, ovf_nxt;

   always_comb begin
      if (tc_q == ROBS_SIGNED)
         ovf_nxt = ~((&prod_nxt[2*WIDTH-1:WIDTH-1]) | ~(|prod_nxt[2*WIDTH-1:WIDTH-1]));
      else
         ovf_nxt = |prod_nxt[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      a_d       = a_q;
      tc_d      = tc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
`ifdef ROBS_OVF_EN
      ovf_d     = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               x_d     = multiplier;
               y_d     = multiplicand;
               tc_d    = tc;
               a_d     = '0;
               cnt_d   = CW'(WIDTH - 1);
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d = prod_nxt[2*WIDTH-1:WIDTH];
            x_d = prod_nxt[WIDTH-1:0];
            if (cnt_q == '0) begin
               state_d   = DONE;
               product_d = prod_nxt;
`ifdef ROBS_OVF_EN
               ovf_d     = ovf_nxt;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         x_q       <= '0;
         y_q       <= '0;
         a_q       <= '0;
         tc_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         a_q       <= a_d;
         tc_q      <= tc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_robs_mult_seq.sv
// Bench for robs_mult_seq: cycle-level reference model plus directed and random operations.
module tb_robs_mult_seq;

   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic           tc = 1'b0;
   logic [W-1:0]   mult = '0;
   logic [W-1:0]   mcand = '0;
   logic           busy, done;
   logic [2*W-1:0] product;
`ifdef ROBS_OVF_EN
   logic           ovf;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   robs_mult_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .tc           (tc),
      .multiplier   (mult),
      .multiplicand (mcand),
      .busy         (busy),
      .done         (done),
`ifdef ROBS_OVF_EN
      .ovf          (ovf),
`endif
      .product      (product)
   );

   function automatic int ref_int(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
      int a, b;
      if (t) begin
         a = int'($signed(x));
         b = int'($signed(y));
      end else begin
         a = int'(x);
         b = int'(y);
      end
      return a * b;
   endfunction

   function automatic logic [2*W-1:0] ref_prod(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
      int p;
      p = ref_int(t, x, y);
      return p[2*W-1:0];
   endfunction

   function automatic logic ref_ovf(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
      int p;
      p = ref_int(t, x, y);
      if (t) return (p < -(1 << (W-1))) || (p > (1 << (W-1)) - 1);
      return p > (1 << W) - 1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference timeline: an accepted start keeps the unit busy for W edges, then one done cycle.
   int             m_left = 0;
   logic           m_done = 1'b0;
   logic [2*W-1:0] m_prod = '0, pend_prod = '0;
   logic           m_ovf = 1'b0, pend_ovf = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_prod <= '0;
         m_ovf  <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         m_done <= (m_left == 1);
         if (m_left == 1) begin
            m_prod <= pend_prod;
            m_ovf  <= pend_ovf;
         end
      end else begin
         m_done <= 1'b0;
         if (start) begin
            pend_prod <= ref_prod(tc, mult, mcand);
            pend_ovf  <= ref_ovf(tc, mult, mcand);
            m_left    <= W;
         end
      end
   end

   always @(negedge clk) begin
      check("model_busy", 32'(busy), 32'(m_left > 0));
      check("model_done", 32'(done), 32'(m_done));
      check("model_product", 32'(product), 32'(m_prod));
`ifdef ROBS_OVF_EN
      check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
   end

   task automatic issue(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
      tc = t;
      mult = x;
      mcand = y;
      start = 1'b1;
   endtask

   task automatic wait_done(input string name, input logic [2*W-1:0] lit,
                            input logic lit_ovf, input int pulse_at);
      int cyc;
      @(negedge clk);
      cyc = 1;
      start = 1'b0;
      check({name, "_busy"}, 32'(busy), 32'd1);
      while (!done && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (cyc == pulse_at) begin
            start = 1'b1;
            tc = ~tc;
            mult = W'($urandom);
            mcand = W'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      check({name, "_latency"}, 32'(cyc), 32'(W + 1));
      check({name, "_product"}, 32'(product), 32'(lit));
`ifdef ROBS_OVF_EN
      check({name, "_ovf"}, 32'(ovf), 32'(lit_ovf));
`else
      if (lit_ovf === 1'bx) check({name, "_ovf_lit"}, 32'(lit_ovf), 32'd0);
`endif
   endtask

   initial begin
      logic           rt;
      logic [W-1:0]   rx, ry;

      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_product", 32'(product), 32'd0);
`ifdef ROBS_OVF_EN
      check("reset_ovf", 32'(ovf), 32'd0);
`endif
      #2 reset = 1'b1;
      @(negedge clk);

      issue(1'b1, 8'hFD, 8'h05);
      wait_done("s_m3x5", 16'hFFF1, 1'b0, 0);
      issue(1'b1, 8'h80, 8'h80);
      wait_done("s_m128sq", 16'h4000, 1'b1, 0);
      // issued at the done cycle: back-to-back acceptance
      issue(1'b1, 8'h80, 8'h01);
      wait_done("s_b2b_m128x1", 16'hFF80, 1'b0, 0);
      issue(1'b0, 8'hFF, 8'hFF);
      wait_done("u_ffsq", 16'hFE01, 1'b1, 0);
      issue(1'b0, 8'hFD, 8'h05);
      wait_done("u_253x5", 16'h04F1, 1'b1, 0);
      @(negedge clk);
      issue(1'b1, 8'h07, 8'hFA);
      wait_done("s_pulse_7xm6", 16'hFFD6, 1'b0, 3);

      @(negedge clk);
      issue(1'b0, 8'h12, 8'h34);
      repeat (4) @(negedge clk);
      start = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_product", 32'(product), 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      issue(1'b0, 8'h12, 8'h34);
      wait_done("post_rst", 16'h03A8, 1'b1, 0);

      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         rt = 1'($urandom_range(0, 1));
         rx = W'($urandom);
         ry = W'($urandom);
         issue(rt, rx, ry);
         wait_done("rand", ref_prod(rt, rx, ry), ref_ovf(rt, rx, ry),
                   ($urandom_range(0, 7) == 0) ? 4 : 0);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
